// File: rtl/reg_dump_ctrl_pkg.sv
// Shared types and widths for the general-purpose register bank and its dump sequencer.
package reg_dump_ctrl_pkg;
  localparam int REG_W  = 16;
  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    FIN  = 2'd3
  } dump_state_t;
endpackage

// File: rtl/reg_dump_ctrl.sv
// Walks a wrap-around register range, streaming one word per 2 cycles; first valid one cycle after the READ cycle.
// Backpressure: the word is held in HOLD, with no further bank reads, until out_ready; abort ends the dump via FIN.
module reg_dump_ctrl
  import reg_dump_ctrl_pkg::*;
#(
  parameter int NREG = 8,
  parameter int W    = REG_W,
  parameter int AW   = REG_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   count,
  input  logic          abort,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam logic [AW:0] REM_ONE  = (AW+1)'(1);
  localparam logic [AW:0] REM_FULL = (AW+1)'(NREG);

  dump_state_t   r_state;
  dump_state_t   w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_rem;
  logic [W-1:0]  r_out_data;
  logic [AW-1:0] r_out_idx;
  logic          r_out_last;
  logic          w_hs;

  assign w_hs = (r_state == HOLD) && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = READ;
      READ: w_state_nxt = abort ? FIN : HOLD;
      // An abort coinciding with a handshake still delivers that word, then finishes.
      HOLD: begin
        if (abort)     w_state_nxt = FIN;
        else if (w_hs) w_state_nxt = (r_rem == REM_ONE) ? FIN : READ;
      end
      FIN:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_rem      <= '0;
      r_out_data <= '0;
      r_out_idx  <= '0;
      r_out_last <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_ptr <= base;
            r_rem <= (count == '0) ? REM_FULL : count;
          end
        end
        READ: begin
          r_out_data <= rd_data;
          r_out_idx  <= r_ptr;
          r_out_last <= (r_rem == REM_ONE);
        end
        HOLD: begin
          // Pointer wraps naturally because NREG is a power of two.
          if (w_hs && !abort && (r_rem != REM_ONE)) begin
            r_ptr <= r_ptr + 1'b1;
            r_rem <= r_rem - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_en     = (r_state == READ);
  assign rd_addr   = rd_en ? r_ptr : '0;
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FIN);

endmodule
